// File: rtl/window_code_gen.sv
// ============================================================================
// window_code_gen: emits 4-bit codes inside (6..9) or outside the window,
// scanning a persistent candidate counter.  Revision: 1.0
// ============================================================================
`default_nettype none

module window_code_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       sel,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       x4,
  output logic       valid,
  output logic       busy,
  output logic [3:0] hit_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       sel_q;
  logic       in_window;

  assign in_window = (cnt > 4'd5) && (cnt < 4'd10);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      sel_q          <= 1'b0;
      {x1, x2, x3, x4} <= 4'b0000;
      valid          <= 1'b0;
      busy           <= 1'b0;
      hit_cnt        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (req) begin
            sel_q <= sel;
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          // The counter advances on every check, matched or not, so the next
          // request resumes just past the last candidate examined.
          cnt <= cnt + 4'd1;
          if (in_window == sel_q) begin
            {x1, x2, x3, x4} <= cnt;
            valid            <= 1'b1;
            state            <= EMIT;
            if (sel_q && (hit_cnt != 4'hF))
              hit_cnt <= hit_cnt + 4'd1;
          end
        end
        EMIT: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_code_gen.sv
// Self-checking bench for window_code_gen against a simple code-sequence model.
`default_nettype none

module tb_window_code_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       sel = 1'b0;
  logic       x1, x2, x3, x4;
  logic       valid;
  logic       busy;
  logic [3:0] hit_cnt;
  logic [3:0] z;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_cnt  = 0;
  int m_hits = 0;

  assign z = {x1, x2, x3, x4};

  always #5 clk = ~clk;

  window_code_gen dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .sel     (sel),
    .x1      (x1),
    .x2      (x2),
    .x3      (x3),
    .x4      (x4),
    .valid   (valid),
    .busy    (busy),
    .hit_cnt (hit_cnt)
  );

  // Walk the code sequence from the model counter until a code on the wanted
  // side of the window is found; report how many candidates were examined.
  task automatic model_req(input logic s, output int n, output logic [3:0] code);
    bit inside_w;
    n = 0;
    do begin
      code     = 4'(m_cnt);
      inside_w = (m_cnt > 5) && (m_cnt < 10);
      m_cnt    = (m_cnt + 1) % 16;
      n++;
    end while (inside_w != s);
    if (s && m_hits < 15) m_hits++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = 1'b0;
    sel   = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_cnt  = 0;
    m_hits = 0;
  endtask

  // Issue one request; optionally toggle req/sel randomly while busy.
  task automatic issue(input logic s, input bit noise, output int edges,
                       output int extra, output bit busy_ok);
    edges   = -1;
    extra   = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    req = 1'b1;
    sel = s;
    @(posedge clk);
    #1;
    if (noise) begin req = 1'($urandom); sel = 1'($urandom); end
    else req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (valid) begin
        edges = i;
        break;
      end
      if (noise) begin req = 1'($urandom); sel = 1'($urandom); end
    end
    if (noise) begin req = 1'b1; sel = ~s; end
    if (!busy) busy_ok = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (busy) busy_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (valid) extra++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (z !== 4'b0000) begin errors++; $display("FAIL reset_code: got %b want 0000", z); end
    checks++; if (hit_cnt !== 4'd0) begin errors++; $display("FAIL reset_hits: got %0d want 0", hit_cnt); end
  endtask

  task automatic test_directed();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    checks++; if (e !== 7 || n != 7) begin errors++; $display("FAIL first_latency: got %0d want 7", e); end
    checks++; if (z !== 4'b0110) begin errors++; $display("FAIL first_code: got %b want 0110", z); end
    checks++; if (hit_cnt !== 4'd1) begin errors++; $display("FAIL first_hits: got %0d want 1", hit_cnt); end
    checks++; if (!b || x != 0) begin errors++; $display("FAIL first_busy_valid: busy_ok %0d extra %0d want 1 0", b, x); end
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    checks++; if (e !== 1) begin errors++; $display("FAIL second_latency: got %0d want 1", e); end
    checks++; if (z !== 4'b0111) begin errors++; $display("FAIL second_code: got %b want 0111", z); end
    checks++; if (hit_cnt !== 4'd2) begin errors++; $display("FAIL second_hits: got %0d want 2", hit_cnt); end
    model_req(1'b0, n, c);
    issue(1'b0, 1'b0, e, x, b);
    checks++; if (e !== 3) begin errors++; $display("FAIL out_latency: got %0d want 3", e); end
    checks++; if (z !== 4'b1010) begin errors++; $display("FAIL out_code: got %b want 1010", z); end
    checks++; if (hit_cnt !== 4'd2) begin errors++; $display("FAIL out_hits: got %0d want 2", hit_cnt); end
  endtask

  task automatic test_hold();
    logic [3:0] held;
    held = z;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (z !== held || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL hold: code %b valid %b busy %b want %b 0 0", z, valid, busy, held);
      end
    end
  endtask

  task automatic test_wrap();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      model_req(1'b1, n, c);
      issue(1'b1, 1'b0, e, x, b);
    end
    checks++; if (z !== 4'd9 || m_cnt != 10) begin errors++; $display("FAIL wrap_setup: got %b want 1001", z); end
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    checks++; if (e !== 13 || n != 13) begin errors++; $display("FAIL wrap_latency: got %0d want 13", e); end
    checks++; if (z !== 4'b0110) begin errors++; $display("FAIL wrap_code: got %b want 0110", z); end
    // cnt must now be 7: a following in-window request emits 7 in one edge.
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    checks++; if (e !== 1 || z !== 4'b0111) begin errors++; $display("FAIL wrap_resume: got %0d/%b want 1/0111", e, z); end
  endtask

  task automatic test_ignore();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic s;
      s = 1'($urandom);
      model_req(s, n, c);
      issue(s, 1'b1, e, x, b);
      checks++;
      if (e !== n || z !== c || hit_cnt !== 4'(m_hits) || x != 0 || !b) begin
        errors++;
        $display("FAIL ignore_busy: lat %0d code %b hits %0d extra %0d busy_ok %0d want %0d %b %0d 0 1",
                 e, z, hit_cnt, x, b, n, c, m_hits);
      end
    end
  endtask

  task automatic test_saturate();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model_req(1'b1, n, c);
      issue(1'b1, 1'b0, e, x, b);
      checks++;
      if (e !== n || z !== c || hit_cnt !== 4'(m_hits)) begin
        errors++;
        $display("FAIL saturate_step%0d: lat %0d code %b hits %0d want %0d %b %0d",
                 i, e, z, hit_cnt, n, c, m_hits);
      end
    end
    checks++; if (hit_cnt !== 4'd15) begin errors++; $display("FAIL saturate_final: got %0d want 15", hit_cnt); end
  endtask

  task automatic test_reset_mid();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    @(negedge clk);
    req = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt  = 0;
    m_hits = 0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || z !== 4'b0000 || hit_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: busy %b valid %b code %b hits %0d want 0 0 0000 0", busy, valid, z, hit_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet: valid %b busy %b want 0 0", valid, busy);
      end
    end
    model_req(1'b1, n, c);
    issue(1'b1, 1'b0, e, x, b);
    checks++; if (e !== 7 || z !== 4'b0110 || hit_cnt !== 4'd1) begin
      errors++; $display("FAIL reset_mid_after: lat %0d code %b hits %0d want 7 0110 1", e, z, hit_cnt);
    end
  endtask

  task automatic test_random();
    int e, x, n; bit b; logic [3:0] c;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      logic s;
      bit nz;
      int gap;
      s   = 1'($urandom);
      nz  = 1'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) @(posedge clk);
      model_req(s, n, c);
      issue(s, nz, e, x, b);
      checks++;
      if (e !== n || z !== c || hit_cnt !== 4'(m_hits) || x != 0 || !b) begin
        errors++;
        $display("FAIL random%0d: lat %0d code %b hits %0d extra %0d busy_ok %0d want %0d %b %0d 0 1",
                 i, e, z, hit_cnt, x, b, n, c, m_hits);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_wrap();
    test_ignore();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
